// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-cycle memory port between two requesters:
//   m0 = CPU data port, m1 = loader.
// Each access takes three cycles (IDLE -> ACCESS -> RESP). Requests are only
// sampled in IDLE. The winner's command is latched on that edge, presented to
// memory during ACCESS, and acknowledged with a one-cycle pulse in RESP.
//
// Parameters:
//   ADDR_W     address width (requesters and memory port)
//   DATA_W     data width (requesters and memory port)
//   FIXED_PRIO 0 = round-robin on ties, 1 = m1 always wins ties
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   mK_req/we/addr/wdata         requester K command (K = 0, 1), held until ack
//   mK_ack                       one-cycle completion pulse to requester K
//   mK_rdata                     read result for requester K, valid with ack
//   mem_addr/mem_wdata/mem_we    shared memory port command
//   mem_rdata                    shared memory port read data (same cycle)
//   busy                         high whenever the arbiter is not idle
//
// Optional feature (macro ARB_STATS_EN):
//   stat_grant0/stat_grant1      16-bit saturating per-requester ack counters
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]       stat_grant0,
    output logic [15:0]       stat_grant1
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_last_grant;   // requester granted most recently
    logic                r_grant;        // winner of the in-flight access
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_mem_we;
    logic                r_m0_ack;
    logic                r_m1_ack;
    logic [DATA_W-1:0]   r_m0_rdata;
    logic [DATA_W-1:0]   r_m1_rdata;
    logic                r_busy;

    logic                w_any_req;
    logic                w_grant1;
    logic                w_sel_we;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;
    logic [DATA_W-1:0]   w_rd_result;

    // Winner selection. On a tie, round-robin hands the grant to whoever did
    // not win last; last_grant resets to 1 so m0 wins the first tie.
    always_comb begin
        w_any_req = m0_req | m1_req;
        if (m0_req && m1_req) begin
            w_grant1 = (FIXED_PRIO != 0) ? 1'b1 : ~r_last_grant;
        end else begin
            w_grant1 = m1_req;
        end
        w_sel_we    = w_grant1 ? m1_we    : m0_we;
        w_sel_addr  = w_grant1 ? m1_addr  : m0_addr;
        w_sel_wdata = w_grant1 ? m1_wdata : m0_wdata;
        w_rd_result = r_we ? '0 : mem_rdata;
    end

    // Arbiter FSM with all outputs registered. The command latch is only
    // loaded on IDLE->ACCESS, so requester input changes afterwards cannot
    // disturb the in-flight access and the memory port holds its last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_grant      <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_mem_we     <= 1'b0;
            r_m0_ack     <= 1'b0;
            r_m1_ack     <= 1'b0;
            r_m0_rdata   <= '0;
            r_m1_rdata   <= '0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_state      <= ACCESS;
                        r_grant      <= w_grant1;
                        r_last_grant <= w_grant1;
                        r_we         <= w_sel_we;
                        r_addr       <= w_sel_addr;
                        r_wdata      <= w_sel_wdata;
                        r_mem_we     <= w_sel_we;
                        r_busy       <= 1'b1;
                    end
                end
                ACCESS: begin
                    // Memory returns read data within the ACCESS cycle; capture
                    // it for the winner only, writes return zero.
                    r_state  <= RESP;
                    r_mem_we <= 1'b0;
                    if (r_grant) begin
                        r_m1_rdata <= w_rd_result;
                        r_m1_ack   <= 1'b1;
                    end else begin
                        r_m0_rdata <= w_rd_result;
                        r_m0_ack   <= 1'b1;
                    end
                end
                RESP: begin
                    r_state  <= IDLE;
                    r_m0_ack <= 1'b0;
                    r_m1_ack <= 1'b0;
                    r_busy   <= 1'b0;
                end
                default: begin
                    r_state  <= IDLE;
                    r_mem_we <= 1'b0;
                    r_m0_ack <= 1'b0;
                    r_m1_ack <= 1'b0;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_we    = r_mem_we;
    assign m0_ack    = r_m0_ack;
    assign m1_ack    = r_m1_ack;
    assign m0_rdata  = r_m0_rdata;
    assign m1_rdata  = r_m1_rdata;
    assign busy      = r_busy;

`ifdef ARB_STATS_EN
    logic [15:0] r_stat0;
    logic [15:0] r_stat1;

    // Ack pulses last exactly one cycle, so counting them counts transactions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat0 <= '0;
            r_stat1 <= '0;
        end else begin
            if (r_m0_ack && (r_stat0 != 16'hFFFF)) begin
                r_stat0 <= r_stat0 + 16'd1;
            end
            if (r_m1_ack && (r_stat1 != 16'hFFFF)) begin
                r_stat1 <= r_stat1 + 16'd1;
            end
        end
    end

    assign stat_grant0 = r_stat0;
    assign stat_grant1 = r_stat1;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Drives a round-robin instance (dut) and a fixed-priority instance (dutP)
// from the same inputs. Expected acks are queued when stimulus is applied and
// popped by a monitor when an ack appears.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
    logic [AW-1:0] m0_addr = '0, m1_addr = '0;
    logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
    logic [DW-1:0] memRdata = '0;

    logic          m0_ack, m1_ack, mem_we, busy;
    logic [DW-1:0] m0_rdata, m1_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;

    logic          p_m0_ack, p_m1_ack, p_mem_we, p_busy;
    logic [DW-1:0] p_m0_rdata, p_m1_rdata, p_mem_wdata;
    logic [AW-1:0] p_mem_addr;

`ifdef ARB_STATS_EN
    logic [15:0]   stat_grant0, stat_grant1, p_stat_grant0, p_stat_grant1;
`endif

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(memRdata), .busy(busy)
`ifdef ARB_STATS_EN
        , .stat_grant0(stat_grant0), .stat_grant1(stat_grant1)
`endif
    );

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1)) dutP (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(p_m0_ack), .m0_rdata(p_m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(p_m1_ack), .m1_rdata(p_m1_rdata),
        .mem_addr(p_mem_addr), .mem_wdata(p_mem_wdata), .mem_we(p_mem_we),
        .mem_rdata(memRdata), .busy(p_busy)
`ifdef ARB_STATS_EN
        , .stat_grant0(p_stat_grant0), .stat_grant1(p_stat_grant1)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          port;
        logic [DW-1:0] rdata;
    } exp_t;

    typedef struct {
        logic          port;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] memRd;
        logic [DW-1:0] expRd;
    } vec_t;

    exp_t          sbQ[$];
    exp_t          sbE;
    int            ackTimes[$];
    int            checks = 0;
    int            errors = 0;
    int            cycleCnt = 0;
    int            ackCount = 0;
    int            p0Acks = 0;
    int            p1Acks = 0;
    int            statExp0 = 0;
    int            statExp1 = 0;
    logic [DW-1:0] expRd0 = '0;
    logic [DW-1:0] expRd1 = '0;
    vec_t          vecs[6];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Ack monitor: samples 1 time unit after each rising edge and compares
    // every ack against the head of the scoreboard queue.
    always @(posedge clk) begin
        cycleCnt++;
        #1;
        if (p_m0_ack) p0Acks++;
        if (p_m1_ack) p1Acks++;
        if (m0_ack || m1_ack) begin
            ackCount++;
            ackTimes.push_back(cycleCnt);
            if (m0_ack) statExp0++;
            if (m1_ack) statExp1++;
            checkOutput("ack exclusive", {63'd0, m0_ack & m1_ack}, 64'd0);
            if (sbQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected ack: got m0_ack=%0b m1_ack=%0b, expected no ack", m0_ack, m1_ack);
            end else begin
                sbE = sbQ.pop_front();
                checkOutput("ack port", {63'd0, m1_ack}, {63'd0, sbE.port});
                if (sbE.port) expRd1 = sbE.rdata;
                else          expRd0 = sbE.rdata;
                checkOutput("m0_rdata", {32'd0, m0_rdata}, {32'd0, expRd0});
                checkOutput("m1_rdata", {32'd0, m1_rdata}, {32'd0, expRd1});
            end
        end
    end

    // Single-requester transaction; entered at a falling edge one cycle
    // before the DUT is idle, leaves during RESP with the request dropped.
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        checkOutput("idle busy", {63'd0, busy}, 64'd0);
        if (v.port) begin
            m1_req = 1'b1; m1_we = v.we; m1_addr = v.addr; m1_wdata = v.wdata;
        end else begin
            m0_req = 1'b1; m0_we = v.we; m0_addr = v.addr; m0_wdata = v.wdata;
        end
        memRdata = v.memRd;
        sbQ.push_back('{port: v.port, rdata: v.expRd});
        @(negedge clk);
        checkOutput("access busy", {63'd0, busy}, 64'd1);
        checkOutput("access mem_addr", {32'd0, mem_addr}, {32'd0, v.addr});
        checkOutput("access mem_we", {63'd0, mem_we}, {63'd0, v.we});
        if (v.we) checkOutput("access mem_wdata", {32'd0, mem_wdata}, {32'd0, v.wdata});
        // Late changes on the requester side must not leak into the access.
        if (v.port) begin
            m1_we = ~v.we; m1_addr = ~v.addr; m1_wdata = ~v.wdata;
        end else begin
            m0_we = ~v.we; m0_addr = ~v.addr; m0_wdata = ~v.wdata;
        end
        @(negedge clk);
        checkOutput("resp mem_we", {63'd0, mem_we}, 64'd0);
        checkOutput("resp mem_addr hold", {32'd0, mem_addr}, {32'd0, v.addr});
        checkOutput("resp ack", {62'd0, m1_ack, m0_ack}, v.port ? 64'd2 : 64'd1);
        m0_req = 1'b0; m1_req = 1'b0;
    endtask

    // Both requesters held high from an idle falling edge just after reset;
    // round-robin must alternate starting with m0, fixed priority always m1.
    task automatic runTie(input int n, input logic [DW-1:0] rd);
        int startCyc;
        int target;
        ackTimes.delete();
        p0Acks = 0;
        p1Acks = 0;
        startCyc = cycleCnt;
        target = ackCount + n;
        memRdata = rd;
        m0_we = 1'b0; m0_addr = 32'h100;
        m1_we = 1'b0; m1_addr = 32'h200;
        m0_req = 1'b1; m1_req = 1'b1;
        for (int i = 0; i < n; i++) sbQ.push_back('{port: logic'(i % 2), rdata: rd});
        for (int k = 0; k < 3 * n + 10 && ackCount < target; k++) @(negedge clk);
        checkOutput("tie ack count", 64'(ackCount), 64'(target));
        m0_req = 1'b0; m1_req = 1'b0;
        if (ackTimes.size() > 0)
            checkOutput("tie first latency", 64'(ackTimes[0] - startCyc), 64'd2);
        for (int i = 1; i < ackTimes.size(); i++)
            checkOutput("tie ack spacing", 64'(ackTimes[i] - ackTimes[i-1]), 64'd3);
        checkOutput("fixed prio m1 acks", 64'(p1Acks), 64'(n));
        checkOutput("fixed prio m0 acks", 64'(p0Acks), 64'd0);
    endtask

    initial begin
        vecs[0] = '{port: 1'b0, we: 1'b0, addr: 32'h10, wdata: 32'h0, memRd: 32'hDEADBEEF, expRd: 32'hDEADBEEF};
        vecs[1] = '{port: 1'b1, we: 1'b1, addr: 32'h20, wdata: 32'h1234, memRd: 32'h5555AAAA, expRd: 32'h0};
        vecs[2] = '{port: 1'b1, we: 1'b0, addr: 32'h24, wdata: 32'h0, memRd: 32'h0F0F0F0F, expRd: 32'h0F0F0F0F};
        vecs[3] = '{port: 1'b0, we: 1'b1, addr: 32'hFFFFFFFC, wdata: 32'hFFFFFFFF, memRd: 32'h13579BDF, expRd: 32'h0};
        vecs[4] = '{port: 1'b0, we: 1'b0, addr: 32'h0, wdata: 32'h0, memRd: 32'hFFFFFFFF, expRd: 32'hFFFFFFFF};
        vecs[5] = '{port: 1'b1, we: 1'b0, addr: 32'h80000000, wdata: 32'h0, memRd: 32'h00000001, expRd: 32'h00000001};

        // Reset values
        repeat (2) @(negedge clk);
        checkOutput("reset m0_ack", {63'd0, m0_ack}, 64'd0);
        checkOutput("reset m1_ack", {63'd0, m1_ack}, 64'd0);
        checkOutput("reset mem_we", {63'd0, mem_we}, 64'd0);
        checkOutput("reset busy", {63'd0, busy}, 64'd0);
        checkOutput("reset mem_addr", {32'd0, mem_addr}, 64'd0);
        checkOutput("reset mem_wdata", {32'd0, mem_wdata}, 64'd0);
        checkOutput("reset m0_rdata", {32'd0, m0_rdata}, 64'd0);
        checkOutput("reset m1_rdata", {32'd0, m1_rdata}, 64'd0);
        rst_n = 1'b1;

        // Ties right after reset, grant possible on first rising edge
        runTie(4, 32'h0BADF00D);

        // Table-driven single transactions
        foreach (vecs[i]) applyStimulus(vecs[i]);

        // Reset in the middle of a write access
        @(negedge clk);
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h40; m0_wdata = 32'hCAFE;
        @(negedge clk);
        checkOutput("pre-reset mem_we", {63'd0, mem_we}, 64'd1);
        #2;
        rst_n = 1'b0;
        m0_req = 1'b0;
        expRd0 = '0; expRd1 = '0;
        statExp0 = 0; statExp1 = 0;
        #1;
        checkOutput("mid reset mem_we", {63'd0, mem_we}, 64'd0);
        checkOutput("mid reset busy", {63'd0, busy}, 64'd0);
        checkOutput("mid reset ack", {62'd0, m1_ack, m0_ack}, 64'd0);
        checkOutput("mid reset mem_addr", {32'd0, mem_addr}, 64'd0);
        checkOutput("mid reset m0_rdata", {32'd0, m0_rdata}, 64'd0);
        checkOutput("mid reset m1_rdata", {32'd0, m1_rdata}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int acksBefore;
            acksBefore = ackCount;
            repeat (5) @(negedge clk);
            checkOutput("no ack after reset", 64'(ackCount), 64'(acksBefore));
            checkOutput("idle after reset busy", {63'd0, busy}, 64'd0);
        end

        // last_grant must be back at its reset value: m0 wins the tie again
        runTie(2, 32'h600DCAFE);

        repeat (4) @(negedge clk);
        checkOutput("scoreboard drained", 64'(sbQ.size()), 64'd0);
`ifdef ARB_STATS_EN
        checkOutput("stat_grant0", {48'd0, stat_grant0}, 64'(statExp0));
        checkOutput("stat_grant1", {48'd0, stat_grant1}, 64'(statExp1));
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
